// File: rtl/dot_sched.sv
// Round-robin scheduler sharing one dot-product engine among NREQ requesters.
// Arbitrates, muxes operands, pulses engine clear/start, waits with timeout, returns tagged result.
module dot_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned VLEN    = 32,
    parameter int unsigned DW      = 8,
    parameter int unsigned RW      = 16,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned IW     = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*VLEN*DW-1:0]  req_a,
    input  logic [NREQ*VLEN*DW-1:0]  req_b,
    output logic [NREQ-1:0]          req_done,
    output logic [VLEN*DW-1:0]       eng_a,
    output logic [VLEN*DW-1:0]       eng_b,
    output logic                     eng_start,
    output logic                     eng_rst_n,
    input  logic [RW-1:0]            eng_c,
    input  logic                     eng_done,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IW-1:0]            rsp_id,
    output logic [RW-1:0]            rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [15:0]              job_cnt,
    output logic [7:0]               err_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CLR, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   gnt_next;
    logic            gnt_found;
    logic [TW-1:0]   timer;

    // First requesting index at or above rr_ptr, wrapping around.
    always_comb begin : grant_search
        int unsigned cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_next  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(rr_ptr) + k) % NREQ;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_next  = IW'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_found) state_d = CLR;
            CLR:     state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (eng_done || timer == TMO_LAST) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        eng_start = (state_q == ISSUE);
        eng_rst_n = rst_n & (state_q != CLR);
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
        rsp_id    = gnt_idx;
        req_done  = '0;
        if (state_q == RESP && rsp_ready) req_done[gnt_idx] = 1'b1;
        if (state_q == IDLE) begin
            eng_a = '0;
            eng_b = '0;
        end else begin
            eng_a = req_a[gnt_idx*VLEN*DW +: VLEN*DW];
            eng_b = req_b[gnt_idx*VLEN*DW +: VLEN*DW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            timer    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            job_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            unique case (state_q)
                IDLE:  if (gnt_found) gnt_idx <= gnt_next;
                ISSUE: timer <= '0;
                WAIT: begin
                    timer <= timer + TW'(1);
                    if (eng_done) begin
                        rsp_data <= eng_c;
                        rsp_err  <= 1'b0;
                    end else if (timer == TMO_LAST) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end
                end
                RESP: if (rsp_ready) begin
                    job_cnt <= job_cnt + 16'd1;
                    rr_ptr  <= IW'((32'(gnt_idx) + 32'd1) % NREQ);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_sched.sv
// Directed testbench for dot_sched with a behavioural dot-product engine model.
module tb_dot_sched;

    localparam int unsigned NREQ = 4, VLEN = 32, DW = 8, RW = 16, TIMEOUT = 64;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ*VLEN*DW-1:0] req_a = '0, req_b = '0;
    logic [NREQ-1:0]         req_done;
    logic [VLEN*DW-1:0]      eng_a, eng_b;
    logic                    eng_start, eng_rst_n;
    logic [RW-1:0]           eng_c = '0;
    logic                    eng_done = 1'b0;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b1;
    logic [1:0]              rsp_id;
    logic [RW-1:0]           rsp_data;
    logic                    rsp_err;
    logic                    busy;
    logic [15:0]             job_cnt;
    logic [7:0]              err_cnt;

    int checks = 0;
    int errors = 0;

    dot_sched #(.NREQ(NREQ), .VLEN(VLEN), .DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_done(req_done), .eng_a(eng_a), .eng_b(eng_b), .eng_start(eng_start),
        .eng_rst_n(eng_rst_n), .eng_c(eng_c), .eng_done(eng_done), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .job_cnt(job_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Engine model: result latched at start, sticky done after lat cycles unless hung.
    bit          hang = 1'b0;
    int unsigned lat = 3;
    int unsigned cd = 0;
    bit          running = 1'b0;
    int          start_cnt = 0;

    function automatic logic [RW-1:0] dot(input logic [VLEN*DW-1:0] a, input logic [VLEN*DW-1:0] b);
        logic [RW-1:0] s;
        s = '0;
        for (int unsigned j = 0; j < VLEN; j++) s = s + RW'(a[j*DW +: DW]) * RW'(b[j*DW +: DW]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (eng_start) start_cnt <= start_cnt + 1;
        if (!eng_rst_n) begin
            eng_done <= 1'b0;
            running  <= 1'b0;
            eng_c    <= '0;
        end else if (eng_start) begin
            eng_c    <= dot(eng_a, eng_b);
            cd       <= lat;
            running  <= 1'b1;
        end else if (running && !hang) begin
            if (cd <= 1) begin
                eng_done <= 1'b1;
                running  <= 1'b0;
            end else cd <= cd - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int unsigned r, input logic [7:0] av, input logic [7:0] bv, input bit ramp);
        for (int unsigned j = 0; j < VLEN; j++) begin
            req_a[(r*VLEN+j)*DW +: DW] = ramp ? 8'(j) : av;
            req_b[(r*VLEN+j)*DW +: DW] = bv;
        end
    endtask

    task automatic wait_for_rsp(output bit ok, output int unsigned cyc);
        ok = 1'b0;
        cyc = 0;
        while (cyc < 500 && !ok) begin
            if (rsp_valid === 1'b1) ok = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
    endtask

    task automatic wait_for_start(output bit ok);
        int unsigned n;
        n = 0;
        ok = 1'b0;
        while (n < 100 && !ok) begin
            if (eng_start === 1'b1) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0h exp 0", rsp_valid); end
        checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL rst_eng_start got %0h exp 0", eng_start); end
        checks++; if (eng_rst_n !== 1'b0) begin errors++; $display("FAIL rst_eng_rst_n got %0h exp 0", eng_rst_n); end
        checks++; if (req_done !== 4'b0000) begin errors++; $display("FAIL rst_req_done got %0h exp 0", req_done); end
        checks++; if (job_cnt !== 16'd0) begin errors++; $display("FAIL rst_job_cnt got %0d exp 0", job_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (rsp_data !== 16'd0 || rsp_err !== 1'b0 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL rst_rsp got data %0d err %0h id %0d exp 0 0 0", rsp_data, rsp_err, rsp_id); end
        checks++; if (eng_a !== '0) begin errors++; $display("FAIL rst_eng_a got %0h exp 0", eng_a); end
        rst_n = 1'b1;
        tick();
        checks++; if (eng_rst_n !== 1'b1) begin errors++; $display("FAIL rel_eng_rst_n got %0h exp 1", eng_rst_n); end
    endtask

    task automatic test_single();
        bit ok;
        int unsigned cyc;
        int s0;
        set_req(0, 8'd1, 8'd2, 1'b0);
        rsp_ready = 1'b1;
        s0 = start_cnt;
        req_valid = 4'b0001;
        tick();
        checks++; if (eng_rst_n !== 1'b0 || eng_start !== 1'b0) begin
            errors++; $display("FAIL single_clr got rst_n %0h start %0h exp 0 0", eng_rst_n, eng_start); end
        checks++; if (eng_a[7:0] !== 8'd1 || eng_b[255:248] !== 8'd2) begin
            errors++; $display("FAIL single_mux got a0 %0d b31 %0d exp 1 2", eng_a[7:0], eng_b[255:248]); end
        tick();
        checks++; if (eng_start !== 1'b1 || eng_rst_n !== 1'b1) begin
            errors++; $display("FAIL single_issue got start %0h rst_n %0h exp 1 1", eng_start, eng_rst_n); end
        wait_for_rsp(ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL single_wait got timeout exp rsp_valid"); end
        checks++; if (rsp_id !== 2'd0 || rsp_data !== 16'd64 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL single_rsp got id %0d data %0d err %0h exp 0 64 0", rsp_id, rsp_data, rsp_err); end
        checks++; if (req_done !== 4'b0001) begin errors++; $display("FAIL single_done got %b exp 0001", req_done); end
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_starts got %0d exp 1", start_cnt - s0); end
        req_valid = 4'b0000;
        tick();
        checks++; if (job_cnt !== 16'd1 || busy !== 1'b0 || req_done !== 4'b0000) begin
            errors++; $display("FAIL single_after got cnt %0d busy %0h done %b exp 1 0 0000", job_cnt, busy, req_done); end
    endtask

    task automatic test_rr_pair();
        bit ok;
        int unsigned cyc;
        do_reset();
        set_req(1, 8'd0, 8'd1, 1'b1);
        set_req(3, 8'd0, 8'd0, 1'b0);
        req_valid = 4'b1010;
        wait_for_rsp(ok, cyc);
        checks++; if (!ok || rsp_id !== 2'd1 || rsp_data !== 16'd496 || req_done !== 4'b0010) begin
            errors++; $display("FAIL pair_first got ok %0d id %0d data %0d done %b exp 1 1 496 0010", ok, rsp_id, rsp_data, req_done); end
        req_valid = 4'b1000;
        tick();
        wait_for_rsp(ok, cyc);
        checks++; if (!ok || rsp_id !== 2'd3 || rsp_data !== 16'd0 || req_done !== 4'b1000) begin
            errors++; $display("FAIL pair_second got ok %0d id %0d data %0d done %b exp 1 3 0 1000", ok, rsp_id, rsp_data, req_done); end
        req_valid = 4'b0000;
        tick();
        checks++; if (job_cnt !== 16'd2) begin errors++; $display("FAIL pair_cnt got %0d exp 2", job_cnt); end
    endtask

    task automatic test_fair();
        bit ok;
        int unsigned cyc;
        logic [1:0]  exp_id [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [15:0] exp_dt [4] = '{16'd32, 16'd64, 16'd96, 16'd128};
        do_reset();
        for (int unsigned i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'd1, 1'b0);
        req_valid = 4'b1111;
        for (int unsigned n = 0; n < 8; n++) begin
            wait_for_rsp(ok, cyc);
            checks++; if (!ok || rsp_id !== exp_id[n] || rsp_data !== exp_dt[exp_id[n]]) begin
                errors++; $display("FAIL fair_job%0d got ok %0d id %0d data %0d exp 1 %0d %0d", n, ok, rsp_id, rsp_data, exp_id[n], exp_dt[exp_id[n]]); end
            tick();
        end
        req_valid = 4'b0000;
        checks++; if (job_cnt !== 16'd8) begin errors++; $display("FAIL fair_cnt got %0d exp 8", job_cnt); end
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int unsigned cyc;
        do_reset();
        hang = 1'b1;
        set_req(2, 8'd2, 8'd3, 1'b0);
        req_valid = 4'b0100;
        wait_for_start(ok);
        tick();
        wait_for_rsp(ok, cyc);
        checks++; if (!ok || cyc != TIMEOUT) begin errors++; $display("FAIL tmo_latency got %0d exp %0d", cyc, TIMEOUT); end
        checks++; if (rsp_err !== 1'b1 || rsp_data !== 16'd0 || rsp_id !== 2'd2 || err_cnt !== 8'd1) begin
            errors++; $display("FAIL tmo_rsp got err %0h data %0d id %0d ecnt %0d exp 1 0 2 1", rsp_err, rsp_data, rsp_id, err_cnt); end
        req_valid = 4'b0000;
        tick();
        hang = 1'b0;
        req_valid = 4'b0100;
        wait_for_rsp(ok, cyc);
        checks++; if (!ok || rsp_err !== 1'b0 || rsp_data !== 16'd192 || err_cnt !== 8'd1) begin
            errors++; $display("FAIL tmo_next got ok %0d err %0h data %0d ecnt %0d exp 1 0 192 1", ok, rsp_err, rsp_data, err_cnt); end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_stall();
        bit ok, stable;
        int unsigned cyc;
        int s0;
        do_reset();
        set_req(0, 8'd1, 8'd2, 1'b0);
        set_req(1, 8'd1, 8'd1, 1'b0);
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        wait_for_rsp(ok, cyc);
        checks++; if (!ok || rsp_id !== 2'd0) begin errors++; $display("FAIL stall_first got ok %0d id %0d exp 1 0", ok, rsp_id); end
        s0 = start_cnt;
        stable = 1'b1;
        for (int unsigned n = 0; n < 20; n++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd64 || rsp_err !== 1'b0 ||
                busy !== 1'b1 || eng_start !== 1'b0 || req_done !== 4'b0000) stable = 1'b0;
        end
        checks++; if (!stable || start_cnt != s0) begin
            errors++; $display("FAIL stall_hold got stable %0d starts %0d exp 1 0", stable, start_cnt - s0); end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_done !== 4'b0001) begin errors++; $display("FAIL stall_release got %b exp 0001", req_done); end
        req_valid = 4'b0010;
        tick();
        checks++; if (req_done !== 4'b0000 || rsp_valid !== 1'b0 || job_cnt !== 16'd1) begin
            errors++; $display("FAIL stall_single got done %b valid %0h cnt %0d exp 0000 0 1", req_done, rsp_valid, job_cnt); end
        wait_for_rsp(ok, cyc);
        checks++; if (!ok || rsp_id !== 2'd1 || rsp_data !== 16'd32) begin
            errors++; $display("FAIL stall_next got ok %0d id %0d data %0d exp 1 1 32", ok, rsp_id, rsp_data); end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int unsigned cyc;
        do_reset();
        set_req(1, 8'd1, 8'd1, 1'b0);
        req_valid = 4'b0010;
        wait_for_rsp(ok, cyc);
        req_valid = 4'b0000;
        tick();
        checks++; if (job_cnt !== 16'd1) begin errors++; $display("FAIL mid_pre_cnt got %0d exp 1", job_cnt); end
        set_req(0, 8'd1, 8'd2, 1'b0);
        set_req(3, 8'd0, 8'd0, 1'b0);
        lat = 10;
        req_valid = 4'b1001;
        wait_for_start(ok);
        tick();
        tick();
        checks++; if (!ok || rsp_id !== 2'd3 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_grant got ok %0d id %0d busy %0h exp 1 3 1", ok, rsp_id, busy); end
        rst_n = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || job_cnt !== 16'd0 || rsp_id !== 2'd0 ||
                      req_done !== 4'b0000 || eng_rst_n !== 1'b0 || eng_a !== '0) begin
            errors++; $display("FAIL mid_reset got busy %0h valid %0h cnt %0d id %0d done %b rst_n %0h exp 0 0 0 0 0000 0",
                               busy, rsp_valid, job_cnt, rsp_id, req_done, eng_rst_n); end
        rst_n = 1'b1;
        wait_for_rsp(ok, cyc);
        checks++; if (!ok || rsp_id !== 2'd0 || rsp_data !== 16'd64) begin
            errors++; $display("FAIL mid_regrant got ok %0d id %0d data %0d exp 1 0 64", ok, rsp_id, rsp_data); end
        req_valid = 4'b0000;
        lat = 3;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_pair();
        test_fair();
        test_timeout();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_sched.md
# dot_sched

Round-robin scheduler that shares one `matrix_dot` dot-product engine (32×8-bit operands, 16-bit result) among `NREQ` requesters. It arbitrates, muxes the winner's operand vectors onto the engine, clears and starts the engine, waits for completion with a timeout, and returns the result on a single valid/ready response channel tagged with the requester ID. It sits between the NPU's compute clients and the engine instance.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `VLEN`, 32: elements per operand vector.
- `DW`, 8: element width.
- `RW`, 16: result width.
- `TIMEOUT`, 64: maximum WAIT cycles before a job is aborted (≥ VLEN+4).

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in NREQ: per-requester job request (level).
- `req_a`, `req_b` in NREQ*VLEN*DW: operands. Element j of requester i is at `[(i*VLEN+j)*DW +: DW]`.
- `req_done` out NREQ: one-hot pulse on the response handshake for the served requester.
- `eng_a`, `eng_b` out VLEN*DW: operands to the engine. Element j is at `[j*DW +: DW]`.
- `eng_start` out 1: engine start pulse.
- `eng_rst_n` out 1: engine reset, active low.
- `eng_c` in RW: engine result.
- `eng_done` in 1: engine done. Sticky-high until the engine is reset.
- `rsp_valid` out 1; `rsp_ready` in 1: response handshake.
- `rsp_id` out clog2(NREQ): ID of the served requester.
- `rsp_data` out RW: result.
- `rsp_err` out 1: timeout flag.
- `busy` out 1: state ≠ IDLE.
- `job_cnt` out 16: completed responses. Wraps.
- `err_cnt` out 8: timeouts. Saturates at 255.

## Operation
- States and transitions: IDLE → CLR → ISSUE → WAIT → RESP → IDLE.
- **IDLE:**
  - If any `req_valid` is set, the grant goes to the first set bit searching upward from `rr_ptr`, wrapping.
  - The winner is registered into `gnt_idx` and the state moves to CLR.
  - With no request, the state holds.
- **CLR:** `eng_rst_n`=0 for exactly one cycle. This clears the engine's sticky `done`.
- **ISSUE:** `eng_start`=1 for exactly one cycle. The timer is cleared to 0.
- **WAIT:**
  - The timer increments each cycle.
  - If `eng_done`=1: capture `eng_c` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - Else if timer == TIMEOUT-1: set `rsp_data`=0, `rsp_err`=1, increment `err_cnt` (saturating), go to RESP.
  - `eng_done` takes priority if both conditions hold in the same cycle.
- **RESP:**
  - `rsp_valid`=1, with `rsp_id`=`gnt_idx` held stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`: `req_done[gnt_idx]` pulses (combinational decode of the handshake), `job_cnt`++, `rr_ptr` ← (`gnt_idx`+1) mod NREQ, go to IDLE.
- **Operand mux:** `eng_a`/`eng_b` = operands of requester `gnt_idx`, held from CLR through WAIT. In IDLE they are driven to 0.
- **Requester rule:** operands must stay stable while `req_valid[i]`=1 until `req_done[i]`.
  - The requester drops `req_valid` in the cycle after `req_done`, or keeps it high with new operands to post a new job.
  - Once granted, a requester that drops `req_valid` early is still served and still gets a response.
- **Arithmetic:** no arithmetic on data; `eng_c` is passed through unchanged.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `gnt_idx`=0, `eng_start`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `rsp_id`=0, `req_done`=0, `busy`=0, `job_cnt`=0, `err_cnt`=0.
- `eng_rst_n` = `rst_n` AND NOT(state==CLR), so the engine is also held in reset whenever `rst_n`=0.
- Cycle sequence: `req_valid` seen at edge 0 → CLR in cycle 1 → `eng_start` in cycle 2. If `eng_done` is first seen k cycles after the start cycle, `rsp_valid` rises 1 cycle later.
- Minimum turnaround is 4 cycles plus engine latency plus response stall.
- The RESP handshake cycle returns to IDLE. The next grant is registered at the following edge, giving one idle cycle between jobs.
- **Reset mid-operation:** `rst_n`=0 in any state returns to IDLE at the next edge. No response or `req_done` is emitted for the aborted job, and the counters clear.
- `rsp_valid`=1 with `rsp_ready`=0 holds all response outputs stable indefinitely. No timeout applies in RESP.

## Test plan
- Single job on requester 0, a[j]=1, b[j]=2, `rsp_ready`=1:
  - `eng_start` pulses once, preceded by one `eng_rst_n`=0 cycle.
  - Response: `rsp_id`=0, `rsp_data`=64, `rsp_err`=0, `req_done`=0001, `job_cnt`=1.
- Requesters 1 and 3 assert together at reset (`rr_ptr`=0):
  - Served in order 1 then 3.
  - Requester 1: a[j]=j, b[j]=1 → 496. Requester 3: a=b=0 → 0.
- All 4 requesters held valid for 8 jobs: `rsp_id` sequence 0,1,2,3,0,1,2,3, with no requester starved.
- Engine model never raises done:
  - `rsp_valid` rises TIMEOUT cycles after WAIT is entered.
  - Response: `rsp_err`=1, `rsp_data`=0, `err_cnt`=1.
  - The next job proceeds normally.
- `rsp_ready` held low for 20 cycles in RESP: outputs stable, `busy`=1, no new `eng_start`. On release, a single `req_done` pulse.
- `rst_n` pulled low for 1 cycle during WAIT:
  - Outputs return to their reset values with no `rsp_valid`, and `job_cnt`=0.
  - A pending request is re-granted from `rr_ptr`=0.
